// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scans a 3x4 keypad row by row, debounces whole frames and queues one code per press.
// The MCU drains the codes through a small first-word-fall-through FIFO; each queued code raises an interrupt pulse.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 22727,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int INT_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       C,
  input  logic       A,
  input  logic       E,
  output logic       B,
  output logic       G,
  output logic       F,
  output logic       D,
  input  logic       ack,
  output logic [3:0] data,
  output logic       valid,
  output logic       interrupt,
  output logic       overflow
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(INT_CYCLES + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_MAX = BW'(DEBOUNCE);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] INT_LEN = IW'(INT_CYCLES);

  typedef enum logic [3:0] {ROW_B = 4'b0001, ROW_G = 4'b0010, ROW_F = 4'b0100, ROW_D = 4'b1000} row_e;
  typedef enum logic [1:0] {CLS_NONE, CLS_KEY, CLS_INV} cls_e;

  logic [DW-1:0] div_q, div_d;
  row_e row_q, row_d;
  logic [2:0] s1_q, s1_d, s2_q, s2_d;
  logic [3:0][2:0] frame_q, frame_d;
  logic [BW-1:0] dcnt_q, dcnt_d, dcnt_n;
  cls_e pcls_q, pcls_d, cls;
  logic [3:0] pcode_q, pcode_d, code, idx, ones;
  logic armed_q, armed_d, push_q, push_d;
  logic [3:0] push_code_q, push_code_d;
  logic [FIFO_DEPTH-1:0][3:0] mem_q, mem_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, head;
  logic [AW:0] cnt_q, cnt_d;
  logic [3:0] data_q, data_d;
  logic valid_q, valid_d, ovf_q, ovf_d;
  logic [IW-1:0] int_q, int_d;
  logic tick, frame_end, same, accept, pop, push_ok;
  logic [1:0] row_idx;
  logic [11:0] flat;

  always_comb begin
    tick = div_q == DIV_MAX;
    div_d = tick ? '0 : div_q + 1'b1;
    s1_d = {E, A, C};
    s2_d = s1_q;
    row_idx = row_q == ROW_G ? 2'd1 : row_q == ROW_F ? 2'd2 : row_q == ROW_D ? 2'd3 : 2'd0;
    row_d = !tick ? row_q : row_q == ROW_B ? ROW_G : row_q == ROW_G ? ROW_F : row_q == ROW_F ? ROW_D : ROW_B;
    frame_d = frame_q;
    if (tick) frame_d[row_idx] = s2_q;
    frame_end = tick && row_q == ROW_D;
    // classify the frame including the row slot being latched on this very tick
    flat = frame_d;
    ones = 4'($countones(flat));
    idx = '0;
    for (int i = 0; i < 12; i++) if (flat[i]) idx = 4'(i);
    cls = ones == 4'd0 ? CLS_NONE : ones == 4'd1 ? CLS_KEY : CLS_INV;
    code = idx < 4'd9 ? idx + 4'd1 : idx == 4'd9 ? 4'hA : idx == 4'd10 ? 4'h0 : 4'hB;
    same = cls == pcls_q && (cls != CLS_KEY || code == pcode_q);
    dcnt_n = cls == CLS_INV ? '0 : !same ? BW'(1) : dcnt_q == DB_MAX ? DB_MAX : dcnt_q + 1'b1;
    accept = cls != CLS_INV && dcnt_n == DB_MAX;
    dcnt_d = frame_end ? dcnt_n : dcnt_q;
    pcls_d = frame_end ? cls : pcls_q;
    pcode_d = frame_end ? code : pcode_q;
    armed_d = frame_end && accept ? cls == CLS_NONE : armed_q;
    push_d = frame_end && accept && cls == CLS_KEY && armed_q;
    push_code_d = frame_end ? code : push_code_q;
    pop = ack && valid_q;
    push_ok = push_q && (cnt_q != DEPTH || pop);
    head = pop ? rd_q + 1'b1 : rd_q;
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = push_code_q;
    rd_d = head;
    wr_d = push_ok ? wr_q + 1'b1 : wr_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    valid_d = cnt_d != '0;
    // mem_d already holds a code written this cycle, so a push into an emptying FIFO falls straight through
    data_d = cnt_d == '0 ? data_q : mem_d[head];
    ovf_d = ovf_q || (push_q && !push_ok);
    int_d = push_ok ? INT_LEN : int_q != '0 ? int_q - 1'b1 : int_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q <= '0;
      row_q <= ROW_B;
      s1_q <= '0;
      s2_q <= '0;
      frame_q <= '0;
      dcnt_q <= '0;
      pcls_q <= CLS_NONE;
      pcode_q <= '0;
      armed_q <= 1'b1;
      push_q <= 1'b0;
      push_code_q <= '0;
      mem_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      int_q <= '0;
    end else begin
      div_q <= div_d;
      row_q <= row_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      frame_q <= frame_d;
      dcnt_q <= dcnt_d;
      pcls_q <= pcls_d;
      pcode_q <= pcode_d;
      armed_q <= armed_d;
      push_q <= push_d;
      push_code_q <= push_code_d;
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
      int_q <= int_d;
    end
  end

  assign {D, F, G, B} = row_q;
  assign data = data_q;
  assign valid = valid_q;
  assign interrupt = int_q != '0;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: reactive keypad model driving the controller, checked every cycle against a frame-level reference model.
module tb_keypad_scan_ctrl;
  localparam int SD = 4, DB = 2, DEPTH = 4, INTC = 3, FR = 4 * SD;
  logic CLK = 0, RST = 0, C = 0, A = 0, E = 0, ack = 0;
  logic B, G, F, D, valid, interrupt, overflow;
  logic [3:0] data;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE(DB), .FIFO_DEPTH(DEPTH), .INT_CYCLES(INTC)) dut (
    .CLK(CLK), .RST(RST), .C(C), .A(A), .E(E), .B(B), .G(G), .F(F), .D(D),
    .ack(ack), .data(data), .valid(valid), .interrupt(interrupt), .overflow(overflow));

  always #5 CLK = ~CLK;

  typedef struct { int row; int col; logic [3:0] code; } key_vec_t;

  int checks = 0, failures = 0;
  int cyc, run, last_push, int_hi;
  logic [11:0] key_mask, frame_mask, prev_mask;
  bit armed, ovf, ack_rand, ack_hold, ack_on_push;
  int q[$];
  logic [3:0] last_data;
  int kmap[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; q.delete(); last_data = 0; ovf = 0; last_push = -1000;
    armed = 1; run = 0; prev_mask = 0; frame_mask = 0; key_mask = 0;
  endtask

  // one clock cycle: compare outputs, evaluate the finished frame, drive inputs, update the model
  task automatic step();
    bit ev, pop;
    int code, d;
    check("rows", {28'd0, D, F, G, B}, 32'(1) << ((cyc / SD) % 4));
    check("valid", valid, q.size() != 0);
    check("data", data, q.size() != 0 ? q[0] : last_data);
    d = cyc - last_push;
    check("interrupt", interrupt, d >= 1 && d <= INTC);
    check("overflow", overflow, ovf);
    if (interrupt) int_hi++;
    ev = 0; code = 0;
    if (cyc % FR == 0) begin
      if (cyc > 0) begin
        if ($countones(frame_mask) >= 2) run = 0;
        else if (run > 0 && frame_mask == prev_mask) run++;
        else run = 1;
        prev_mask = frame_mask;
        if (run >= DB && frame_mask == 0) armed = 1;
        else if (run >= DB && $countones(frame_mask) == 1) begin
          if (armed) begin
            ev = 1;
            for (int i = 0; i < 12; i++) if (frame_mask[i]) code = kmap[i];
          end
          armed = 0;
        end
      end
      frame_mask = key_mask;
    end
    ack = ack_on_push ? ev : ack_rand ? ($urandom_range(3) == 0) : ack_hold;
    C = (B & frame_mask[0]) | (G & frame_mask[3]) | (F & frame_mask[6]) | (D & frame_mask[9]);
    A = (B & frame_mask[1]) | (G & frame_mask[4]) | (F & frame_mask[7]) | (D & frame_mask[10]);
    E = (B & frame_mask[2]) | (G & frame_mask[5]) | (F & frame_mask[8]) | (D & frame_mask[11]);
    pop = ack && q.size() > 0;
    if (pop) void'(q.pop_front());
    if (ev) begin
      if (q.size() < DEPTH) begin
        q.push_back(code);
        last_push = cyc;
      end else ovf = 1;
    end
    if (q.size() != 0) last_data = q[0];
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_frames(logic [11:0] m, int n);
    while (cyc % FR != 0) step();
    key_mask = m;
    repeat (n * FR) step();
  endtask

  task automatic press(int idx);
    run_frames(12'(1) << idx, 3);
    run_frames(12'h000, 2);
  endtask

  task automatic do_reset();
    RST = 1; ack = 0; C = 0; A = 0; E = 0;
    #1;
    check("rst_rows", {28'd0, D, F, G, B}, 32'h1);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_interrupt", interrupt, 0);
    check("rst_overflow", overflow, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    key_vec_t vecs[12];
    int exp4[4];
    int r;
    logic [11:0] m;
    vecs = '{'{0, 0, 4'h1}, '{0, 1, 4'h2}, '{0, 2, 4'h3},
             '{1, 0, 4'h4}, '{1, 1, 4'h5}, '{1, 2, 4'h6},
             '{2, 0, 4'h7}, '{2, 1, 4'h8}, '{2, 2, 4'h9},
             '{3, 0, 4'hA}, '{3, 1, 4'h0}, '{3, 2, 4'hB}};
    exp4 = '{2, 3, 4, 9};
    ack_rand = 0; ack_hold = 0; ack_on_push = 0;
    model_reset();
    #2;
    do_reset();
    int_hi = 0;
    run_frames(12'h000, 2);
    check("idle_valid", valid, 0);
    check("idle_int", int_hi, 0);

    run_frames(12'h010, 3);
    check("k5_valid", valid, 1);
    check("k5_data", data, 5);
    check("k5_int_len", int_hi, 3);
    run_frames(12'h010, 10);
    check("k5_no_repeat", int_hi, 3);
    ack_hold = 1;
    run_frames(12'h000, 2);
    ack_hold = 0;
    check("k5_drained", valid, 0);

    int_hi = 0;
    press(11);
    press(11);
    check("hash_first", data, 4'hB);
    check("hash_int", int_hi, 6);
    ack_hold = 1;
    step();
    check("hash_second", data, 4'hB);
    check("hash_second_valid", valid, 1);
    step();
    ack_hold = 0;
    check("hash_empty", valid, 0);

    run_frames(12'h003, 5);
    check("multi_valid", valid, 0);
    check("multi_ovf", overflow, 0);
    run_frames(12'h000, 2);

    int_hi = 0;
    press(0); press(1); press(2); press(3); press(5);
    check("ovf_set", overflow, 1);
    check("ovf_int_pulses", int_hi, 12);
    check("ovf_head", data, 1);
    ack_on_push = 1;
    run_frames(12'h100, 3);
    ack_on_push = 0;
    run_frames(12'h000, 2);
    check("full_pushpop_head", data, 2);
    check("full_pushpop_int", int_hi, 15);
    for (int i = 0; i < 4; i++) begin
      check("drain", data, exp4[i]);
      ack_hold = 1;
      step();
      ack_hold = 0;
    end
    check("drain_empty", valid, 0);

    for (int i = 0; i < 12; i++) begin
      press(vecs[i].row * 3 + vecs[i].col);
      check("keymap_valid", valid, 1);
      check("keymap_code", data, vecs[i].code);
      ack_hold = 1;
      step();
      ack_hold = 0;
    end

    press(6);
    run_frames(12'h080, 2);
    step();
    check("pre_rst_valid", valid, 1);
    check("pre_rst_int", interrupt, 1);
    do_reset();
    int_hi = 0;
    run_frames(12'h000, 4);
    check("post_rst_valid", valid, 0);
    check("post_rst_int", int_hi, 0);
    run_frames(12'h200, 3);
    check("post_rst_press", data, 4'hA);
    check("post_rst_press_valid", valid, 1);

    ack_rand = 1;
    repeat (60) begin
      r = $urandom_range(9);
      if (r < 4) m = 12'h000;
      else if (r < 9) m = 12'(1) << $urandom_range(11);
      else m = (12'(1) << $urandom_range(11)) | (12'(1) << $urandom_range(11));
      run_frames(m, $urandom_range(1, 4));
    end
    ack_rand = 0;
    run_frames(12'h000, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
